// File: rtl/perf_arbiter.sv
// Round-robin arbiter sharing one perf cycle-count monitor between NUM_REQ requesters.
// The owner's start/done/busy are forwarded to the monitor and its final counts are banked per requester.
module perf_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int IDX_W         = $clog2(NUM_REQ),
    parameter int CAP_TIMEOUT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_start,
    input  logic [NUM_REQ-1:0]       req_done,
    input  logic [NUM_REQ-1:0]       req_busy,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [IDX_W-1:0]         gnt_idx,
    output logic                     mon_start_pulse,
    output logic                     mon_done_pulse,
    output logic                     mon_busy,
    input  logic [COUNTER_WIDTH-1:0] mon_total,
    input  logic [COUNTER_WIDTH-1:0] mon_active,
    input  logic [COUNTER_WIDTH-1:0] mon_idle,
    input  logic                     mon_measurement_done,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [COUNTER_WIDTH-1:0] rd_total,
    output logic [COUNTER_WIDTH-1:0] rd_active,
    output logic [COUNTER_WIDTH-1:0] rd_idle,
    output logic                     rd_valid,
    input  logic [NUM_REQ-1:0]       clr_valid,
    output logic                     err_timeout,
    output logic                     err_proto
);

    localparam int TMR_W = $clog2(CAP_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_MEASURE, S_CAPTURE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     err_t_q, err_t_d;
    logic                     err_p_q, err_p_d;
    logic [NUM_REQ-1:0]       valid_q, valid_d;
    logic [COUNTER_WIDTH-1:0] tot_q [NUM_REQ];
    logic [COUNTER_WIDTH-1:0] act_q [NUM_REQ];
    logic [COUNTER_WIDTH-1:0] idl_q [NUM_REQ];

    logic                     cap_we;
    logic                     start_c, done_c, busy_c;
    logic [NUM_REQ-1:0]       own_oh;
    logic                     own_req, own_start, own_done, own_busy;
    logic                     pick_found;
    logic [IDX_W-1:0]         pick_idx;

    // First requester after last_q, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] j;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

    assign {pick_found, pick_idx} = rr_pick(req, last_q);

    assign own_oh    = NUM_REQ'(1) << gnt_idx_q;
    assign own_req   = req[gnt_idx_q];
    assign own_start = req_start[gnt_idx_q];
    assign own_done  = req_done[gnt_idx_q];
    assign own_busy  = req_busy[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        timer_d   = timer_q;
        err_t_d   = err_t_q;
        err_p_d   = err_p_q;
        start_c   = 1'b0;
        done_c    = 1'b0;
        busy_c    = 1'b0;
        cap_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (enable && pick_found) begin
                    gnt_idx_d = pick_idx;
                    last_d    = pick_idx;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                if (own_start) begin
                    start_c = 1'b1;
                    state_d = S_MEASURE;
                    if (own_done) err_p_d = 1'b1;
                end else if (!own_req) begin
                    state_d = S_IDLE;
                end
            end
            S_MEASURE: begin
                busy_c = own_busy;
                done_c = own_done;
                // A repeated start or an early req drop is a requester bug; measurement still runs to done.
                if (own_start || (!own_req && !own_done)) err_p_d = 1'b1;
                if (own_done) begin
                    timer_d = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (mon_measurement_done) begin
                    cap_we  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == TMR_W'(CAP_TIMEOUT - 1)) begin
                    err_t_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture takes priority over a coincident clear.
    assign valid_d = (valid_q & ~clr_valid) | (cap_we ? own_oh : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            timer_q   <= '0;
            err_t_q   <= 1'b0;
            err_p_q   <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tot_q[i] <= '0;
                act_q[i] <= '0;
                idl_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            err_t_q   <= err_t_d;
            err_p_q   <= err_p_d;
            valid_q   <= valid_d;
            if (cap_we) begin
                tot_q[gnt_idx_q] <= mon_total;
                act_q[gnt_idx_q] <= mon_active;
                idl_q[gnt_idx_q] <= mon_idle;
            end
        end
    end

    // Reset silences the grant and the monitor controls in the same cycle.
    assign gnt             = (state_q != S_IDLE && !rst) ? own_oh : '0;
    assign gnt_idx         = gnt_idx_q;
    assign mon_start_pulse = start_c & ~rst;
    assign mon_done_pulse  = done_c & ~rst;
    assign mon_busy        = busy_c & ~rst;
    assign err_timeout     = err_t_q;
    assign err_proto       = err_p_q;

    always_comb begin
        rd_total  = '0;
        rd_active = '0;
        rd_idle   = '0;
        rd_valid  = 1'b0;
        if (int'(rd_idx) < NUM_REQ) begin
            rd_total  = tot_q[rd_idx];
            rd_active = act_q[rd_idx];
            rd_idle   = idl_q[rd_idx];
            rd_valid  = valid_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_perf_arbiter.sv
// Directed bench for perf_arbiter with a small behavioural perf monitor attached.
module tb_perf_arbiter;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst, enable;
    logic [N-1:0]  req, req_start, req_done, req_busy, clr_valid, gnt;
    logic [IW-1:0] gnt_idx, rd_idx;
    logic          mon_start_pulse, mon_done_pulse, mon_busy, mon_measurement_done;
    logic [CW-1:0] mon_total, mon_active, mon_idle, rd_total, rd_active, rd_idle;
    logic          rd_valid, err_timeout, err_proto;

    int vectors    = 0;
    int miscompares = 0;
    int start_cnt  = 0;
    int multi_gnt  = 0;
    bit auto_done  = 1'b1;
    bit running    = 1'b0;
    int capc, sc;

    always #5 clk = ~clk;

    perf_arbiter #(.NUM_REQ(N), .COUNTER_WIDTH(CW), .CAP_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .req_start(req_start),
        .req_done(req_done), .req_busy(req_busy), .gnt(gnt), .gnt_idx(gnt_idx),
        .mon_start_pulse(mon_start_pulse), .mon_done_pulse(mon_done_pulse),
        .mon_busy(mon_busy), .mon_total(mon_total), .mon_active(mon_active),
        .mon_idle(mon_idle), .mon_measurement_done(mon_measurement_done),
        .rd_idx(rd_idx), .rd_total(rd_total), .rd_active(rd_active),
        .rd_idle(rd_idle), .rd_valid(rd_valid), .clr_valid(clr_valid),
        .err_timeout(err_timeout), .err_proto(err_proto)
    );

    // Monitor model: counts every cycle after start up to and including done.
    always @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            mon_total <= '0; mon_active <= '0; mon_idle <= '0;
            mon_measurement_done <= 1'b0;
        end else begin
            mon_measurement_done <= 1'b0;
            if (mon_start_pulse) begin
                running <= 1'b1;
                mon_total <= '0; mon_active <= '0; mon_idle <= '0;
                start_cnt <= start_cnt + 1;
            end else if (running) begin
                mon_total <= mon_total + 1;
                if (mon_busy) mon_active <= mon_active + 1;
                else          mon_idle   <= mon_idle + 1;
                if (mon_done_pulse) begin
                    running <= 1'b0;
                    mon_measurement_done <= auto_done;
                end
            end
        end
    end

    always @(negedge clk) if ($countones(gnt) > 1) multi_gnt <= multi_gnt + 1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input int idx, input int t, input int a, input int i, input bit v);
        rd_idx = IW'(idx);
        #1;
        chk($sformatf("rd_total[%0d]", idx), rd_total, t);
        chk($sformatf("rd_active[%0d]", idx), rd_active, a);
        chk($sformatf("rd_idle[%0d]", idx), rd_idle, i);
        chk($sformatf("rd_valid[%0d]", idx), rd_valid, v);
    endtask

    // inj: 0 none, 1 non-owner start/done pulses, 2 owner repeats start mid-measure.
    task automatic run_job(input int idx, input int dly, input int len, input int nbusy,
                           input bit drop, input int inj, input bit clr, output int cap_n);
        int w;
        w = 0;
        while (gnt == '0 && w < 8) begin tick(); w++; end
        chk("gnt_idx", gnt_idx, idx);
        chk("gnt_onehot", gnt, 1 << idx);
        repeat (dly) tick();
        req_start[idx] = 1'b1;
        #1;
        chk("mon_start", mon_start_pulse, 1);
        tick();
        req_start = '0;
        for (int i = 0; i < len; i++) begin
            req_busy[idx] = (i < nbusy);
            req_done[idx] = (i == len - 1);
            if (inj == 1 && i == 0) begin
                req_start[idx ^ 3] = 1'b1;
                req_done[idx ^ 3]  = 1'b1;
                #1;
                chk("iso_start", mon_start_pulse, 0);
                chk("iso_done", mon_done_pulse, 0);
            end
            if (inj == 2 && i == 1) begin
                req_start[idx] = 1'b1;
                #1;
                chk("dup_start", mon_start_pulse, 0);
            end
            tick();
            req_start = '0; req_done = '0; req_busy = '0;
        end
        if (drop) req[idx] = 1'b0;
        cap_n = 0;
        do begin
            if (clr && cap_n == 0) clr_valid[idx] = 1'b1;
            tick();
            clr_valid = '0;
            cap_n++;
        end while (gnt != '0 && cap_n < 8);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; req = '0; req_start = '0; req_done = '0;
        req_busy = '0; clr_valid = '0; rd_idx = '0;
        repeat (2) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_idx", gnt_idx, 0);
        chk("rst_mon", {mon_start_pulse, mon_done_pulse, mon_busy}, 0);
        chk("rst_err", {err_timeout, err_proto}, 0);
        rd_chk(0, 0, 0, 0, 0);

        // Single owner: grant one cycle after req, start two cycles later, 6 busy of 10.
        rst = 1'b0; req = 4'b0010;
        tick();
        chk("single_gnt_latency", gnt, 4'b0010);
        sc = start_cnt;
        run_job(1, 2, 10, 6, 1, 0, 0, capc);
        chk("single_cap_cycles", capc, 1);
        chk("single_start_count", start_cnt - sc, 1);
        rd_chk(1, 10, 6, 4, 1);
        chk("single_err_proto", err_proto, 0);

        // Round robin from fresh reset: order 0,1,2,3,0.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("rr_first_gnt", gnt, 4'b0001);
        run_job(0, 0, 3, 1, 0, 0, 0, capc);
        run_job(1, 0, 3, 1, 0, 0, 0, capc);
        run_job(2, 0, 3, 1, 0, 0, 0, capc);
        run_job(3, 0, 3, 1, 0, 0, 0, capc);
        run_job(0, 0, 3, 1, 0, 0, 0, capc);
        req = '0;
        rd_chk(2, 3, 1, 2, 1);

        // Abandon: clear valid[2], grant 2, drop before start, then 3 is granted.
        clr_valid = 4'b0100; tick(); clr_valid = '0;
        rd_chk(2, 3, 1, 2, 0);
        rd_chk(3, 3, 1, 2, 1);
        req = 4'b1100;
        tick();
        chk("abandon_gnt", gnt, 4'b0100);
        sc = start_cnt;
        req = 4'b1000;
        tick();
        chk("abandon_release", gnt, 0);
        chk("abandon_no_start", mon_start_pulse, 0);
        tick();
        chk("abandon_next_gnt", gnt, 4'b1000);
        chk("abandon_start_count", start_cnt - sc, 0);
        rd_chk(2, 3, 1, 2, 0);
        req = '0;
        tick();
        chk("abandon3_release", gnt, 0);

        // Non-owner isolation while 0 measures.
        req = 4'b0001;
        run_job(0, 0, 4, 2, 1, 1, 0, capc);
        rd_chk(0, 4, 2, 2, 1);
        chk("iso_err_proto", err_proto, 0);

        // Capture timeout: monitor never completes.
        chk("pre_err_timeout", err_timeout, 0);
        auto_done = 1'b0;
        req = 4'b0010;
        run_job(1, 0, 5, 5, 1, 0, 0, capc);
        chk("timeout_cycles", capc, 4);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_idle_gnt", gnt, 0);
        rd_chk(1, 3, 1, 2, 1);

        // Clear coinciding with capture: capture wins.
        auto_done = 1'b1;
        req = 4'b0001;
        run_job(0, 0, 3, 3, 1, 0, 1, capc);
        rd_chk(0, 3, 3, 0, 1);
        clr_valid = 4'b0001; tick(); clr_valid = '0;
        rd_chk(0, 3, 3, 0, 0);

        // enable=0 holds off a grant; then a repeated owner start flags err_proto.
        enable = 1'b0; req = 4'b0100;
        tick(); tick();
        chk("enable_block", gnt, 0);
        enable = 1'b1;
        tick();
        chk("enable_gnt", gnt, 4'b0100);
        sc = start_cnt;
        run_job(2, 0, 3, 0, 1, 2, 0, capc);
        chk("dup_err_proto", err_proto, 1);
        chk("dup_start_count", start_cnt - sc, 1);
        rd_chk(2, 3, 0, 3, 1);

        chk("no_multi_gnt", multi_gnt, 0);
        chk("err_timeout_sticky", err_timeout, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
